// File: rtl/mult_div_unit_pkg.sv
// mdu_pkg: op codes, FSM encoding and constants shared by the multiply/divide unit.
package mdu_pkg;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_e;
  localparam int MDU_ITER = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request, HI/LO move and result bus of the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, a, b, mthi, mtlo, wdata, input busy, done, hi, lo);
  modport slave (input start, op, a, b, mthi, mtlo, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-cycle shift-add multiplier and restoring divider writing HI/LO.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mult_div_unit_if.slave bus
);
  state_e      state, state_n;
  op_e         op_q;
  logic [31:0] opa, opb;
  logic        neg_q, neg_r, div0;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [32:0] rem;
  logic [31:0] hi_q, lo_q;
  logic        sgn, is_div, last, idle_start;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, prod;
  logic [33:0] r_sh, diff;
  logic [32:0] rem_next;
  logic [31:0] q_next, quo, rmd;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? CALC : IDLE;
      CALC:    state_n = last ? DONE : CALC;
      default: state_n = IDLE;
    endcase
  end
  assign sgn        = ~bus.op[0];
  assign is_div     = op_q[1];
  assign idle_start = (state == IDLE) && bus.start;
  assign last       = (state == CALC) && (cnt == 5'(MDU_ITER - 1));
  // Multiply: acc = {partial product, remaining multiplier bits}; divide: acc[31:0] shifts dividend out and quotient in.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign r_sh     = {rem, acc[31]};
  assign diff     = r_sh - {2'b0, opb};
  assign rem_next = diff[33] ? r_sh[32:0] : diff[32:0];
  assign q_next   = {acc[30:0], ~diff[33]};
  assign prod     = neg_q ? -mul_next : mul_next;
  assign quo      = div0 ? DIV0_LO : (neg_q ? -q_next : q_next);
  assign rmd      = div0 ? opa : (neg_r ? -rem_next[31:0] : rem_next[31:0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= OP_MULT;
      opa   <= '0;
      opb   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      rem   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      if (idle_start) begin
        op_q  <= op_e'(bus.op);
        div0  <= bus.op[1] && (bus.b == 32'd0);
        opa   <= (bus.op[1] && (bus.b == 32'd0)) ? bus.a : mag(bus.a, sgn);
        opb   <= mag(bus.b, sgn);
        acc   <= {32'd0, bus.op[1] ? mag(bus.a, sgn) : mag(bus.b, sgn)};
        neg_q <= sgn && (bus.a[31] ^ bus.b[31]);
        neg_r <= sgn && bus.a[31];
        cnt   <= '0;
        rem   <= '0;
      end
      if (state == CALC) begin
        acc <= is_div ? {32'd0, q_next} : mul_next;
        rem <= is_div ? rem_next : rem;
        cnt <= cnt + 5'd1;
      end
      if (last) begin
        hi_q <= is_div ? rmd : prod[63:32];
        lo_q <= is_div ? quo : prod[31:0];
      end else if (state == IDLE && !bus.start) begin
        hi_q <= bus.mthi ? bus.wdata : hi_q;
        lo_q <= bus.mtlo ? bus.wdata : lo_q;
      end
    end
  end
  assign bus.busy = (state == CALC);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001: clk  input  1  — single clock; all state updates on its rising edge.
REQ-002: rst_n  input  1  — reset, asynchronous, active-low.
REQ-003: start  input  1  — request one operation; sampled only in IDLE.
REQ-004: op  input  2  — operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005: a  input  32  — multiplicand or dividend (rs).
REQ-006: b  input  32  — multiplier or divisor (rt).
REQ-007: mthi  input  1  — write wdata to HI; honoured only in IDLE.
REQ-008: mtlo  input  1  — write wdata to LO; honoured only in IDLE.
REQ-009: wdata  input  32  — data for mthi/mtlo.
REQ-010: busy  output  1  — high while an operation is computing; drives the pipeline stall.
REQ-011: done  output  1  — one-cycle pulse when HI/LO hold a new result.
REQ-012: hi  output  32  — HI register, fed to the writeback 4:1 select (mfhi path).
REQ-013: lo  output  32  — LO register, fed to the writeback 4:1 select (mflo path).

Function
REQ-014: FSM states are IDLE, CALC and DONE; transitions are IDLE->CALC on start, CALC->DONE after the 32nd iteration, and DONE->IDLE unconditionally.
REQ-015: On the edge that samples start in IDLE, the unit SHALL latch op, the magnitudes of a and b (signed ops only) and the result-sign flags, and SHALL clear the 5-bit iteration counter.
REQ-016: Multiply SHALL be iterative shift-add, one bit per cycle, with a 64-bit accumulator.
REQ-017: Divide SHALL be restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
REQ-018: busy SHALL be 1 exactly while in CALC, i.e. 32 cycles, starting the cycle after start is sampled.
REQ-019: The edge leaving CALC SHALL write HI/LO; done SHALL be 1 during the single DONE cycle, with new hi/lo visible in that same cycle.
REQ-020: Multiply results: HI = product[63:32] and LO = product[31:0]; a signed product is negated (64-bit two's complement) when the operand signs differ.
REQ-021: Divide results: LO = quotient and HI = remainder; a signed quotient is negated when the signs differ, and the remainder takes the dividend's sign.
REQ-022: Divide by zero is not trapped: HI = a and LO = 32'hFFFFFFFF for both DIVU and DIV, with no sign fixup applied.
REQ-023: 32'h80000000 / 32'hFFFFFFFF (DIV) SHALL give LO = 32'h80000000 and HI = 0.
REQ-024: start, mthi and mtlo SHALL be ignored in CALC and DONE; hi/lo hold their values until the result is written.
REQ-025: Simultaneous start and mthi/mtlo in IDLE: start wins and the mthi/mtlo write is dropped.
REQ-026: Simultaneous mthi and mtlo without start: both registers are written with wdata.
REQ-027: a and b SHALL not be sampled after the start cycle; upstream may change them freely.

Reset
REQ-028: Asserting rst_n low SHALL immediately force state = IDLE, busy = 0, done = 0, hi = 0, lo = 0 and clear the counter and accumulators.
REQ-029: Reset asserted in mid-CALC SHALL abort the operation; no partial result reaches hi/lo.
REQ-030: The first start after reset release SHALL behave identically to any later start.

Structure
REQ-031: A shared package mdu_pkg SHALL hold the op codes (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state encoding, MDU_ITER = 32 and DIV0_LO = 32'hFFFFFFFF.
REQ-032: The block SHALL be a single module; no sub-module is required.
REQ-033: Sign fixup SHALL be combinational on the final accumulator, evaluated at the CALC->DONE edge.

Verification
REQ-034: MULTU a = FFFFFFFF, b = FFFFFFFF -> busy for 32 cycles, then done with HI = FFFFFFFE and LO = 00000001.
REQ-035: MULT a = FFFFFFFD (-3), b = 00000005 -> HI = FFFFFFFF, LO = FFFFFFF1.
REQ-036: DIV a = FFFFFFF9 (-7), b = 00000002 -> LO = FFFFFFFD, HI = FFFFFFFF; DIVU a = 00000064, b = 0 -> HI = 00000064, LO = FFFFFFFF.
REQ-037: Start a MULTU, pulse start/mthi with other operands in CALC cycle 5 -> both ignored; result is that of the first op only.
REQ-038: In IDLE, mthi with wdata = 12345678 and start in the same cycle -> HI is not written and the op runs; then mtlo alone with wdata = CAFEF00D -> LO = CAFEF00D on the next cycle.
REQ-039: Assert rst_n low in CALC cycle 10 -> busy = 0 and hi/lo = 0 immediately; after release, a new MULTU 3 x 4 -> LO = 0000000C.
